eject_merge: RTL and testbench
==============================

EJECT_MERGE -- requirements
Module: eject_merge

Interface
REQ-001 SHALL have parameter FLIT_SIZE, default 128, flit width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, entries per port FIFO; power of 2, minimum 2.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port eject_flit  input  6*FLIT_SIZE  router eject flits; slice i = port i, order xpos, ypos, zpos, xneg, yneg, zneg (i=0..5).
REQ-006 SHALL have port eject_valid  input  6  per-port flit-valid; no backpressure toward the router exists.
REQ-007 SHALL have port out_flit  output  FLIT_SIZE  merged flit to local unit.
REQ-008 SHALL have port out_valid  output  1  out_flit holds a flit.
REQ-009 SHALL have port out_ready  input  1  local unit accepts; transfer when out_valid && out_ready.
REQ-010 SHALL have port out_port  output  3  source port index (0..5) of out_flit.
REQ-011 SHALL have port fifo_full  output  6  per-port FIFO full flag, registered.
REQ-012 SHALL have port drop_cnt  output  6*16  per-port dropped-flit counters (present only per REQ-027).

Function
REQ-013 SHALL write eject_flit slice i into FIFO i on every edge where eject_valid[i]=1 and FIFO i can accept.
REQ-014 FIFO i SHALL accept when not full, or when full and popped in the same cycle.
REQ-015 SHALL discard a flit with eject_valid[i]=1 that FIFO i cannot accept; FIFO contents unchanged.
REQ-016 SHALL preserve arrival order within each port; no ordering guarantee across ports.
REQ-017 Output register SHALL load when (!out_valid || out_ready) and at least one FIFO is non-empty; otherwise hold out_flit, out_port, out_valid unchanged.
REQ-018 Output register SHALL clear out_valid when out_ready=1 and all FIFOs are empty.
REQ-019 Arbitration SHALL be round-robin: grant the first non-empty FIFO scanning from (last_grant+1) mod 6 upward with wrap; last_grant updates only on a load.
REQ-020 Granted FIFO SHALL pop in the same cycle its head loads the output register.
REQ-021 Latency SHALL be: flit sampled at edge k into empty FIFOs with output idle -> out_valid=1 after edge k+1.
REQ-022 Throughput SHALL be one flit per cycle while out_ready=1 and any FIFO is non-empty.
REQ-023 fifo_full[i] SHALL reflect FIFO i occupancy == FIFO_DEPTH after each edge.

Reset
REQ-024 While rst=0: all FIFOs empty; out_valid=0; out_flit=0; out_port=0; fifo_full=0; last_grant=5, so port 0 is first priority; drop_cnt=0.
REQ-025 Assertion mid-operation SHALL discard all buffered and in-flight flits immediately, without a clock edge.
REQ-026 First enqueue SHALL occur on the first rising edge after rst deasserts.

Configuration
REQ-027 With macro EJECT_MERGE_DROP_CNT_EN defined, SHALL instantiate six 16-bit drop counters: drop_cnt slice i increments on each REQ-015 discard at port i and saturates at 0xFFFF.
REQ-028 Without EJECT_MERGE_DROP_CNT_EN, SHALL omit port drop_cnt and all counter logic; discard behaviour unchanged.

Verification
REQ-029 Single flit 0xA5 on port 2 at edge k, out_ready=1 -> out_valid=1 after edge k+1 with out_flit=0xA5, out_port=2, exactly one cycle.
REQ-030 All six ports valid for one cycle, flits 0..5, out_ready=1, after reset -> out_port sequence 0,1,2,3,4,5 on six consecutive cycles.
REQ-031 out_ready=0, port 0 valid for 10 cycles with FIFO_DEPTH=8 -> 1 flit in output register, 8 flits buffered, fifo_full[0]=1, 1 flit discarded, drop_cnt[0]=1 with macro defined.
REQ-032 FIFO 0 full, out_ready=1, eject_valid[0]=1 in the same cycle -> no discard; occupancy stays 8; fifo_full[0] stays 1.
REQ-033 rst asserted while three flits are buffered and out_valid=1 -> out_valid=0 immediately; after release, no stale flit ever emerges.

Source files
------------

// File: rtl/eject_merge.sv
// rtl/eject_merge.sv - six-port router eject merge: per-port FIFOs, round-robin arbiter, registered output.
// Optional per-port saturating drop counters are built when EJECT_MERGE_DROP_CNT_EN is defined.
module eject_merge #(
    parameter int FLIT_SIZE  = 128,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [6*FLIT_SIZE-1:0] eject_flit,
    input  logic [5:0]             eject_valid,
    output logic [FLIT_SIZE-1:0]   out_flit,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2:0]             out_port,
    output logic [5:0]             fifo_full
`ifdef EJECT_MERGE_DROP_CNT_EN
    ,
    output logic [6*16-1:0]        drop_cnt
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [FLIT_SIZE-1:0] mem [6][FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr [6];
    logic [AW-1:0]        rd_ptr [6];
    logic [CW-1:0]        count [6];
    logic [CW-1:0]        count_next [6];

    logic [5:0]           non_empty;
    logic [5:0]           push;
    logic [5:0]           pop;
    logic [2:0]           last_grant;
    logic [2:0]           grant;
    logic                 load;
    logic [FLIT_SIZE-1:0] head;

    always_comb begin
        for (int p = 0; p < 6; p++) begin
            non_empty[p] = (count[p] != '0);
        end
    end

    // Scan from the port after the last winner so every port gets a turn.
    always_comb begin
        logic [2:0] cand;
        logic       found;
        grant = last_grant;
        found = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            cand = 3'((int'(last_grant) + k) % 6);
            if (!found && non_empty[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    assign load = (!out_valid || out_ready) && (|non_empty);
    assign head = mem[grant][rd_ptr[grant]];

    // A full FIFO still accepts when its head leaves in the same cycle.
    always_comb begin
        for (int p = 0; p < 6; p++) begin
            pop[p]  = load && (grant == 3'(p));
            push[p] = eject_valid[p] && (!fifo_full[p] || pop[p]);
            case ({push[p], pop[p]})
                2'b10:   count_next[p] = count[p] + CW'(1);
                2'b01:   count_next[p] = count[p] - CW'(1);
                default: count_next[p] = count[p];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < 6; p++) begin
            if (push[p]) begin
                mem[p][wr_ptr[p]] <= eject_flit[p*FLIT_SIZE +: FLIT_SIZE];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int p = 0; p < 6; p++) begin
                wr_ptr[p] <= '0;
                rd_ptr[p] <= '0;
                count[p]  <= '0;
            end
            fifo_full <= '0;
        end else begin
            for (int p = 0; p < 6; p++) begin
                if (push[p]) begin
                    wr_ptr[p] <= wr_ptr[p] + AW'(1);
                end
                if (pop[p]) begin
                    rd_ptr[p] <= rd_ptr[p] + AW'(1);
                end
                count[p]     <= count_next[p];
                fifo_full[p] <= (count_next[p] == CW'(FIFO_DEPTH));
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_flit   <= '0;
            out_port   <= '0;
            out_valid  <= 1'b0;
            last_grant <= 3'd5;
        end else if (load) begin
            out_flit   <= head;
            out_port   <= grant;
            out_valid  <= 1'b1;
            last_grant <= grant;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

`ifdef EJECT_MERGE_DROP_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt <= '0;
        end else begin
            for (int p = 0; p < 6; p++) begin
                if (eject_valid[p] && !push[p] && (drop_cnt[p*16 +: 16] != 16'hFFFF)) begin
                    drop_cnt[p*16 +: 16] <= drop_cnt[p*16 +: 16] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_eject_merge.sv
// tb/tb_eject_merge.sv - directed scoreboard bench for eject_merge.
module tb_eject_merge;

    localparam int FS = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic [6*FS-1:0] eject_flit;
    logic [5:0]    eject_valid;
    logic [FS-1:0] out_flit;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    out_port;
    logic [5:0]    fifo_full;
`ifdef EJECT_MERGE_DROP_CNT_EN
    logic [95:0]   drop_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;
    logic [130:0] sb[$];

    always #5 clk = ~clk;

    eject_merge #(.FLIT_SIZE(FS), .FIFO_DEPTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .eject_flit(eject_flit),
        .eject_valid(eject_valid),
        .out_flit(out_flit),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_port(out_port),
        .fifo_full(fifo_full)
`ifdef EJECT_MERGE_DROP_CNT_EN
        ,
        .drop_cnt(drop_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A transfer happens at the coming edge when both valid and ready are high now.
    task automatic observe();
        logic [130:0] e;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            chk("sb_nonempty", 128'(sb.size() != 0), 128'(1));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_port", 128'(out_port), 128'(e[130:128]));
                chk("sb_flit", out_flit, e[127:0]);
            end
        end
    endtask

    task automatic step(input logic rdy);
        out_ready = rdy;
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        eject_valid = '0;
        eject_flit = '0;
        out_ready = 1'b0;
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        eject_valid = '0;
        eject_flit = '0;
        out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_flit", out_flit, 128'(0));
        chk("rst_out_port", 128'(out_port), 128'(0));
        chk("rst_fifo_full", 128'(fifo_full), 128'(0));
`ifdef EJECT_MERGE_DROP_CNT_EN
        chk("rst_drop_cnt", 128'(drop_cnt), 128'(0));
`endif
        rst = 1'b1;

        // Single flit latency and one-cycle presence
        eject_flit[2*FS +: FS] = 128'hA5;
        eject_valid = 6'b000100;
        sb.push_back({3'd2, 128'hA5});
        step(1'b1);
        eject_valid = '0;
        chk("lat_edge_k", 128'(out_valid), 128'(0));
        step(1'b1);
        chk("lat_valid", 128'(out_valid), 128'(1));
        chk("lat_flit", out_flit, 128'hA5);
        chk("lat_port", 128'(out_port), 128'(2));
        step(1'b1);
        chk("one_cycle", 128'(out_valid), 128'(0));

        // Round-robin from reset: all six ports at once
        do_reset();
        for (int i = 0; i < 6; i++) begin
            eject_flit[i*FS +: FS] = FS'(i);
            sb.push_back({3'(i), FS'(i)});
        end
        eject_valid = 6'h3F;
        step(1'b1);
        eject_valid = '0;
        step(1'b1);
        for (int i = 0; i < 6; i++) begin
            chk("rr_valid", 128'(out_valid), 128'(1));
            chk("rr_port", 128'(out_port), 128'(i));
            step(1'b1);
        end
        chk("rr_done", 128'(out_valid), 128'(0));
        chk("rr_sb_empty", 128'(sb.size()), 128'(0));

        // Overflow with output stalled: 1 in register, 8 buffered, 1 dropped
        do_reset();
        eject_valid = 6'b000001;
        for (int n = 0; n < 10; n++) begin
            eject_flit[0 +: FS] = FS'(100 + n);
            if (n < 9) sb.push_back({3'd0, FS'(100 + n)});
            step(1'b0);
        end
        eject_valid = '0;
        chk("ovf_full", 128'(fifo_full), 128'(6'b000001));
        chk("ovf_valid", 128'(out_valid), 128'(1));
        chk("ovf_flit", out_flit, 128'(100));
`ifdef EJECT_MERGE_DROP_CNT_EN
        chk("ovf_drop", 128'(drop_cnt[15:0]), 128'(1));
`endif

        // Full FIFO popped and pushed in the same cycle: no discard
        eject_valid = 6'b000001;
        eject_flit[0 +: FS] = FS'(200);
        sb.push_back({3'd0, FS'(200)});
        step(1'b1);
        eject_valid = '0;
        chk("same_cyc_full", 128'(fifo_full[0]), 128'(1));
        chk("same_cyc_flit", out_flit, 128'(101));
`ifdef EJECT_MERGE_DROP_CNT_EN
        chk("same_cyc_drop", 128'(drop_cnt[15:0]), 128'(1));
`endif
        for (int n = 0; n < 12; n++) step(1'b1);
        chk("drain_sb_empty", 128'(sb.size()), 128'(0));
        chk("drain_full", 128'(fifo_full), 128'(0));
        chk("drain_valid", 128'(out_valid), 128'(0));

        // Asynchronous reset with buffered flits
        do_reset();
        eject_valid = 6'b001000;
        for (int n = 0; n < 4; n++) begin
            eject_flit[3*FS +: FS] = FS'(300 + n);
            step(1'b0);
        end
        eject_valid = '0;
        chk("pre_rst_valid", 128'(out_valid), 128'(1));
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_valid", 128'(out_valid), 128'(0));
        chk("async_rst_flit", out_flit, 128'(0));
        chk("async_rst_full", 128'(fifo_full), 128'(0));
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int n = 0; n < 10; n++) begin
            chk("no_stale", 128'(out_valid), 128'(0));
            step(1'b1);
        end
        eject_flit[5*FS +: FS] = 128'h77;
        eject_valid = 6'b100000;
        sb.push_back({3'd5, 128'h77});
        step(1'b1);
        eject_valid = '0;
        for (int n = 0; n < 4; n++) step(1'b1);
        chk("fresh_sb_empty", 128'(sb.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
